// File: rtl/jmul_share_ctrl.sv
// jmul_share_ctrl: shares one combinational 4x4 multiplier between two requesters.
// Round-robin arbitration in IDLE, one MUL cycle for the multiplier to settle, and a
// held response in RESP until the consumer takes it.
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   req0_valid/a/b, req0_ready      requester 0 operand handshake
//   req1_valid/a/b, req1_ready      requester 1 operand handshake
//   mul_a, mul_b, mul_y             external multiplier operands and product
//   rsp_valid, rsp_ready            response handshake
//   rsp_y, rsp_id                   registered product and issuing requester
//   busy                            high while a transaction is in flight
//   chk_err                         sticky product self-check error
// Macro JMUL_SHARE_SELFCHECK_EN builds the product comparator; otherwise chk_err is 0.
module jmul_share_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic [7:0] mul_y,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_id,
    output logic       busy,
    output logic       chk_err
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] op_a, op_b;
    logic       cur_id, last_id;
    logic       grant1, accept;

    // Requester 1 wins when it is alone, or when both ask and requester 0 went last.
    assign grant1 = req1_valid & (~req0_valid | ~last_id);
    assign accept = (state == IDLE) & (req0_valid | req1_valid);
    assign mul_a  = op_a;
    assign mul_b  = op_b;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                req0_ready = req0_valid & ~grant1;
                req1_ready = grant1;
                state_nxt  = accept ? MUL : IDLE;
            end
            MUL:     state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = rsp_ready ? IDLE : RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_a    <= 4'd0;
            op_b    <= 4'd0;
            cur_id  <= 1'b0;
            last_id <= 1'b1;
            rsp_y   <= 8'd0;
            rsp_id  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a    <= grant1 ? req1_a : req0_a;
                op_b    <= grant1 ? req1_b : req0_b;
                cur_id  <= grant1;
                last_id <= grant1;
            end
            if (state == MUL) begin
                rsp_y  <= mul_y;
                rsp_id <= cur_id;
            end
        end
    end

`ifdef JMUL_SHARE_SELFCHECK_EN
    logic [7:0] ref_y;
    assign ref_y = {4'd0, op_a} * {4'd0, op_b};
    always_ff @(posedge clk) begin
        if (reset)
            chk_err <= 1'b0;
        else if (state == MUL && mul_y != ref_y)
            chk_err <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_jmul_share_ctrl.sv
// tb_jmul_share_ctrl: directed and randomized checks of jmul_share_ctrl against a transaction-level model.
module tb_jmul_share_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
    logic [7:0] mul_y, rsp_y;
    logic       rsp_valid, rsp_ready, rsp_id, busy, chk_err;
    bit         bad;

`ifdef JMUL_SHARE_SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    always #5 clk = ~clk;

    // Behavioural multiplier; 'bad' forces a wrong product.
    assign mul_y = bad ? 8'd0 : {4'd0, mul_a} * {4'd0, mul_b};

    jmul_share_ctrl dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
        .busy(busy), .chk_err(chk_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transaction model: one outstanding transaction, 'm_age' cycles since its accept.
    bit         m_txn, m_last, m_id, m_rid, m_err;
    int         m_age;
    logic [3:0] m_a, m_b;
    logic [7:0] m_ry;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_txn = 0; m_last = 1; m_id = 0; m_rid = 0; m_err = 0;
        m_age = 0; m_a = 0; m_b = 0; m_ry = 0;
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic cycle();
        int gid;
        bit rv;
        #1;
        gid = -1;
        if (!m_txn) begin
            if (req0_valid && req1_valid) gid = m_last ? 0 : 1;
            else if (req0_valid)          gid = 0;
            else if (req1_valid)          gid = 1;
        end
        rv = m_txn && m_age == 2;
        check("req0_ready", req0_ready, gid == 0);
        check("req1_ready", req1_ready, gid == 1);
        check("rsp_valid", rsp_valid, rv);
        check("busy", busy, m_txn);
        check("rsp_y", rsp_y, m_ry);
        check("rsp_id", rsp_id, m_rid);
        check("mul_a", mul_a, m_a);
        check("mul_b", mul_b, m_b);
        check("chk_err", chk_err, m_err);
        @(posedge clk);
        if (reset) model_reset();
        else begin
            if (m_txn && m_age == 1) begin
                m_ry  = bad ? 8'd0 : 8'(m_a * m_b);
                m_rid = m_id;
                if (bad && SC) m_err = 1;
                m_age = 2;
            end else if (rv && rsp_ready) m_txn = 0;
            if (gid >= 0) begin
                m_txn = 1; m_age = 1; m_id = gid[0]; m_last = gid[0];
                m_a = gid == 1 ? req1_a : req0_a;
                m_b = gid == 1 ? req1_b : req0_b;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0; bad = 0;
        cycle();
        reset = 0;
    endtask

    task automatic run_one(input bit id, input logic [3:0] a, input logic [3:0] b);
        req0_valid = !id; req0_a = a; req0_b = b;
        req1_valid = id;  req1_a = a; req1_b = b;
        rsp_ready = 1;
        cycle();
        req0_valid = 0; req1_valid = 0;
        cycle();
        check("bnd_valid", rsp_valid, 1);
        check("bnd_y", rsp_y, {4'd0, a} * {4'd0, b});
        check("bnd_id", rsp_id, id);
        cycle();
    endtask

    initial begin
        bit         ids[6];
        logic [7:0] ys[6];
        int         ts[6];
        int         k, c0;
        reset = 1; bad = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        @(posedge clk);
        model_reset();
        #1;
        cycle();
        reset = 0;
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_chk_err", chk_err, 0);

        // Single request 3x5 from requester 0.
        req0_valid = 1; req0_a = 3; req0_b = 5;
        #1 check("single_ready", req0_ready, 1);
        cycle();
        req0_valid = 0;
        cycle();
        check("single_valid", rsp_valid, 1);
        check("single_y", rsp_y, 15);
        check("single_id", rsp_id, 0);
        rsp_ready = 1;
        cycle();

        // Contention and round-robin over six back-to-back transactions.
        do_reset();
        req0_valid = 1; req0_a = 2; req0_b = 2;
        req1_valid = 1; req1_a = 3; req1_b = 4;
        rsp_ready = 1;
        c0 = cyc; k = 0;
        for (int i = 0; i < 40 && k < 6; i++) begin
            cycle();
            if (rsp_valid) begin
                ids[k] = rsp_id; ys[k] = rsp_y; ts[k] = cyc; k++;
            end
        end
        check("rr_count", k, 6);
        if (k > 0) check("rr_latency", ts[0] - c0, 2);
        for (int j = 0; j < k; j++) begin
            check("rr_id", ids[j], j % 2);
            check("rr_y", ys[j], (j % 2) ? 12 : 4);
            if (j > 0) check("rr_spacing", ts[j] - ts[j-1], 3);
        end
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 3; i++) cycle();

        // Backpressure with 3x3 while the other requester keeps asking.
        do_reset();
        req0_valid = 1; req0_a = 3; req0_b = 3;
        cycle();
        req0_valid = 0; req1_valid = 1; req1_a = 1; req1_b = 2;
        cycle();
        for (int i = 0; i < 5; i++) begin
            check("bp_y", rsp_y, 9);
            check("bp_valid", rsp_valid, 1);
            check("bp_busy", busy, 1);
            cycle();
        end
        rsp_ready = 1;
        cycle();
        check("bp_release_busy", busy, 0);
        req1_valid = 0;
        for (int i = 0; i < 3; i++) cycle();

        // Operand boundaries.
        run_one(0, 0, 0);
        run_one(1, 1, 1);
        run_one(0, 15, 15);
        run_one(1, 15, 15);

        // Reset during MUL drops the transaction.
        do_reset();
        req1_valid = 1; req1_a = 7; req1_b = 9; rsp_ready = 1;
        cycle();
        req1_valid = 0; reset = 1;
        cycle();
        reset = 0;
        check("midrst_mul_a", mul_a, 0);
        check("midrst_rsp_y", rsp_y, 0);
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_rsp", rsp_valid, 0);
            cycle();
        end

        // Corrupted multiplier output for 2x2.
        do_reset();
        bad = 1; req0_valid = 1; req0_a = 2; req0_b = 2;
        cycle();
        req0_valid = 0;
        cycle();
        check("sc_err", chk_err, SC);
        check("sc_captured_y", rsp_y, 0);
        rsp_ready = 1;
        cycle();
        bad = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("sc_sticky", chk_err, SC);
        do_reset();
        check("sc_cleared", chk_err, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset      = $urandom_range(0, 79) == 0;
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            req0_a = 4'($urandom); req0_b = 4'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom);
            rsp_ready  = $urandom_range(0, 2) != 0;
            cycle();
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
